xbar_unscramble: RTL

//  Inverse of the 3x3 byte crossbar (select word = s2,s1,s0 at [5:4],[3:2],[1:0]).

---
 rtl/xbar_unscramble.sv | 135 +++++++++++++
 1 files changed

// File: rtl/xbar_unscramble.sv
// Inverse 3x3 byte crossbar: restores source lane order from the crossbar outputs
// and their select word, buffered through a small output FIFO; illegal selects are dropped and counted.
module xbar_unscramble #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [5:0]   sel,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] q0,
  output logic [W-1:0] q1,
  output logic [W-1:0] q2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         err,
  input  logic         err_clr,
  output logic [7:0]   err_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [1:0]     s [3];
  logic [W-1:0]   d [3];
  logic [W-1:0]   lane [3];
  logic           legal;
  logic [3*W-1:0] word_d;

  logic [3*W-1:0] mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [3*W-1:0] hold_q, hold_d;
  logic           err_q, err_d;
  logic [7:0]     err_cnt_q, err_cnt_d;

  logic           full, empty, accept, push, pop;
  logic [3*W-1:0] head, q_word;

  assign s[0] = sel[1:0];
  assign s[1] = sel[3:2];
  assign s[2] = sel[5:4];
  assign d[0] = d0;
  assign d[1] = d1;
  assign d[2] = d2;

  // Only the six permutations of {0,1,2} are legal; lane k takes the input whose select is k.
  always_comb begin
    legal = (s[0] != 2'b11) && (s[1] != 2'b11) && (s[2] != 2'b11) &&
            (s[0] != s[1]) && (s[0] != s[2]) && (s[1] != s[2]);
    for (int unsigned k = 0; k < 3; k++) begin
      lane[k] = '0;
      for (int unsigned j = 0; j < 3; j++) begin
        if (s[j] == 2'(k)) lane[k] = d[j];
      end
    end
    word_d = {lane[2], lane[1], lane[0]};
  end

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign accept    = in_valid && in_ready;
  assign push      = accept && legal;
  assign pop       = out_valid && out_ready;
  assign head      = mem_q[rd_ptr_q];

  // Once drained, the outputs keep showing the last popped word instead of a stale slot.
  assign q_word = empty ? hold_q : head;
  assign q0     = q_word[W-1:0];
  assign q1     = q_word[2*W-1:W];
  assign q2     = q_word[3*W-1:2*W];

  assign err     = err_q;
  assign err_cnt = err_cnt_q;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    hold_d    = hold_q;
    err_d     = accept && !legal;
    err_cnt_d = err_cnt_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      hold_d   = head;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (err_clr) begin
      err_cnt_d = '0;
    end else if (accept && !legal && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      hold_q    <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      hold_q    <= hold_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= word_d;
    end
  end

endmodule
